// File: rtl/safety_scan_ctrl.sv
// safety_scan_ctrl
// Walks the placed-queen rows 0..cand_row-1 one per cycle. Each row is checked
// against the candidate for a shared column or a shared diagonal. The scan
// stops at the first conflict, or reports safe after the last placed row.
module safety_scan_ctrl #(
    parameter int N  = 8,
    parameter int CW = 3,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] cand_row,
    input  logic [CW-1:0] cand_col,
    output logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic          busy,
    output logic          done,
    output logic          safe,
    output logic [RW-1:0] conflict_row,
    output logic [RW:0]   checks
);

    // The distances use one bit more than an index, so the subtraction can never wrap.
    localparam int DW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_cand_row;
    logic [CW-1:0]   r_cand_col;
    logic [RW-1:0]   r_idx;
    logic [RW-1:0]   r_rd_hold;
    logic            r_safe;
    logic [RW-1:0]   r_conflict_row;
    logic [RW:0]     r_checks;

    logic [DW-1:0]   w_cand_col_ext;
    logic [DW-1:0]   w_rd_col_ext;
    logic [DW-1:0]   w_col_dist;
    logic [DW-1:0]   w_row_dist;
    logic            w_conflict;
    logic            w_last;

    assign w_cand_col_ext = DW'(r_cand_col);
    assign w_rd_col_ext   = DW'(rd_col);
    assign w_col_dist     = (w_cand_col_ext >= w_rd_col_ext) ? (w_cand_col_ext - w_rd_col_ext)
                                                             : (w_rd_col_ext - w_cand_col_ext);
    assign w_row_dist     = DW'(r_cand_row) - DW'(r_idx);
    assign w_conflict     = (rd_col == r_cand_col) || (w_col_dist == w_row_dist);
    // A row is only scanned when cand_row >= 1, so cand_row-1 cannot underflow here.
    assign w_last         = (r_idx == (r_cand_row - RW'(1)));

    // The read address follows the scan index while scanning.
    // Otherwise it keeps the last row that was read.
    assign rd_row       = (r_state == SCAN) ? r_idx : r_rd_hold;
    assign safe         = r_safe;
    assign conflict_row = r_conflict_row;
    assign checks       = r_checks;

    // State register; reset drops straight back to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; busy and done come straight from the state so that reset clears them at once.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (cand_row == '0) ? REPORT : SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_conflict || w_last) begin
                    w_next = REPORT;
                end
            end
            REPORT: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the candidate on accept, then step the index and record the verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cand_row     <= '0;
            r_cand_col     <= '0;
            r_idx          <= '0;
            r_rd_hold      <= '0;
            r_safe         <= 1'b0;
            r_conflict_row <= '0;
            r_checks       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cand_row     <= cand_row;
                        r_cand_col     <= cand_col;
                        r_idx          <= '0;
                        r_conflict_row <= '0;
                        r_checks       <= '0;
                        r_safe         <= (cand_row == '0);
                    end
                end
                SCAN: begin
                    r_checks  <= r_checks + (RW+1)'(1);
                    r_rd_hold <= r_idx;
                    if (w_conflict) begin
                        r_safe         <= 1'b0;
                        r_conflict_row <= r_idx;
                    end else if (w_last) begin
                        r_safe <= 1'b1;
                    end else begin
                        r_idx <= r_idx + RW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safety_scan_ctrl.sv
// Testbench for safety_scan_ctrl.
// The board holds a known 8-queens solution (0,4,7,5,2,6,1,3). Table vectors
// give hand-computed verdicts. Hand-written sequences cover an ignored start
// and a reset applied mid-scan.
module tb_safety_scan_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] cand_row = '0;
    logic [CW-1:0] cand_col = '0;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          busy;
    logic          done;
    logic          safe;
    logic [RW-1:0] conflict_row;
    logic [RW:0]   checks;

    logic [CW-1:0] board [N];

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        int row;
        int col;
        int expSafe;
        int expConfRow;
        int expChecks;
        int expLatency;
    } vec_t;

    vec_t vecs [10];

    safety_scan_ctrl #(.N(N), .CW(CW), .RW(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cand_row     (cand_row),
        .cand_col     (cand_col),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .busy         (busy),
        .done         (done),
        .safe         (safe),
        .conflict_row (conflict_row),
        .checks       (checks)
    );

    // Combinational board read port
    assign rd_col = board[rd_row];

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Caller must be at a negedge.
    // Drives start here and returns at the negedge where done is seen.
    // latency is the number of negedges after the accept edge, or -1 on timeout.
    task automatic applyStimulus(input int row, input int col, output int latency);
        cand_row = RW'(row);
        cand_col = CW'(col);
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        latency = 1;
        while (!done && latency < 20) begin
            checkOutput("busyInScan", int'(busy), 1);
            checkOutput("rdRowStep", int'(rd_row), latency - 1);
            @(negedge clk);
            latency++;
        end
        if (!done) begin
            checkOutput("doneTimeout", 0, 1);
            latency = -1;
        end
    endtask

    initial begin
        int lat;

        board[0] = 3'd0; board[1] = 3'd4; board[2] = 3'd7; board[3] = 3'd5;
        board[4] = 3'd2; board[5] = 3'd6; board[6] = 3'd1; board[7] = 3'd3;

        //            row col safe confRow checks latency
        vecs[0] = '{0, 5, 1, 0, 0, 1};
        vecs[1] = '{3, 5, 1, 0, 3, 4};
        vecs[2] = '{3, 4, 0, 1, 2, 3};
        vecs[3] = '{3, 3, 0, 0, 1, 2};
        vecs[4] = '{7, 3, 1, 0, 7, 8};
        vecs[5] = '{1, 2, 1, 0, 1, 2};
        vecs[6] = '{2, 1, 1, 0, 2, 3};
        vecs[7] = '{4, 2, 1, 0, 4, 5};
        vecs[8] = '{5, 1, 0, 4, 5, 6};
        vecs[9] = '{6, 7, 0, 2, 3, 4};

        // Reset values
        #12;
        checkOutput("rstBusy",    int'(busy), 0);
        checkOutput("rstDone",    int'(done), 0);
        checkOutput("rstSafe",    int'(safe), 0);
        checkOutput("rstConfRow", int'(conflict_row), 0);
        checkOutput("rstRdRow",   int'(rd_row), 0);
        checkOutput("rstChecks",  int'(checks), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven scans, issued back to back at the minimum spacing
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].row, vecs[i].col, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLatency);
            checkOutput($sformatf("v%0d_safe", i), int'(safe), vecs[i].expSafe);
            checkOutput($sformatf("v%0d_confRow", i), int'(conflict_row), vecs[i].expConfRow);
            checkOutput($sformatf("v%0d_checks", i), int'(checks), vecs[i].expChecks);
            if (vecs[i].expChecks > 0) begin
                checkOutput($sformatf("v%0d_rdHold", i), int'(rd_row), vecs[i].expChecks - 1);
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d_donePulse", i), int'(done), 0);
            checkOutput($sformatf("v%0d_busyIdle", i), int'(busy), 0);
            checkOutput($sformatf("v%0d_safeHeld", i), int'(safe), vecs[i].expSafe);
        end

        // A start during SCAN is ignored; the verdict belongs to (7,3)
        cand_row = 3'd7;
        cand_col = 3'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        @(negedge clk);
        lat++;
        cand_row = 3'd3;
        cand_col = 3'd4;
        start    = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignLatency", lat, 8);
        checkOutput("ignSafe",    int'(safe), 1);
        checkOutput("ignChecks",  int'(checks), 7);
        @(negedge clk);
        checkOutput("ignIdle",    int'(busy), 0);

        // Reset asserted in the third SCAN cycle of (7,3)
        cand_row = 3'd7;
        cand_col = 3'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midRdRow", int'(rd_row), 2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arstBusy",   int'(busy), 0);
        checkOutput("arstDone",   int'(done), 0);
        checkOutput("arstSafe",   int'(safe), 0);
        checkOutput("arstRdRow",  int'(rd_row), 0);
        checkOutput("arstChecks", int'(checks), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("noDoneInReset", int'(done), 0);
        end
        reset = 1'b1;
        applyStimulus(3, 5, lat);
        checkOutput("postRstLatency", lat, 4);
        checkOutput("postRstSafe",    int'(safe), 1);
        checkOutput("postRstChecks",  int'(checks), 3);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
